uart_tx_sched: RTL
==================

// Module: uart_tx_sched
// PURPOSE
//  Round-robin scheduler sharing one uart_tx byte engine between N_REQ byte-stream requesters.
//  Grants one requester per packet and holds the grant until its byte flagged last has been sent.
//  Feeds uart_tx via tx_data/tx_valid/tx_done and inserts a fixed idle gap between packets.
//  Aborts a packet whose owner stalls mid-packet and flags the abort.
// PARAMETERS
//  N_REQ       4    number of requesters (2..8)
//  GAP_CYCLES  16   clk cycles of forced idle after each packet (0 = none)
//  STALL_TO    1024 cycles a granted requester may withhold the next byte before abort (>=1)
// PORTS
//  clk_i          in   1        system clock
//  rstn_i         in   1        reset, asynchronous, active-low
//  enable_i       in   1        1: new packets may be granted
//  req_valid_i    in   N_REQ    requester i has a byte on req_data_i[8i+:8]
//  req_data_i     in   8*N_REQ  byte per requester
//  req_last_i     in   N_REQ    byte is last of packet
//  req_ready_o    out  N_REQ    1-cycle pulse: byte of requester i accepted
//  tx_data_o      out  8        byte to uart_tx (tx_data_i)
//  tx_valid_o     out  1        to uart_tx tx_valid_i
//  tx_done_i      in   1        from uart_tx tx_done_o, 1-cycle pulse per byte sent
//  grant_o        out  N_REQ    one-hot current owner, 0 when none
//  busy_o         out  1        state != IDLE
//  stall_err_o    out  1        1-cycle pulse on stall abort
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, counters 0; async reset mid-byte drops tx_valid_o at once.
//  States IDLE, LOAD, SEND, GAP (registered).
//  IDLE: if enable_i && |req_valid_i: winner = first valid index at or after pointer (wrapping);
//   grant_q<=winner, ->LOAD. No valid or !enable_i: stay.
//  LOAD: req_ready_o[grant]=req_valid_i[grant] (combinational); on accept latch data_q,last_q,
//   clear stall counter, ->SEND. Else stall counter++; on reaching STALL_TO: pulse stall_err_o,
//   pointer<=grant+1 (wrap), grant cleared, ->GAP.
//  SEND: tx_valid_o=1, tx_data_o=data_q held stable; in the tx_done_i cycle tx_valid_o=0.
//   On tx_done_i: last_q ? (pointer<=grant+1 mod N_REQ, grant cleared, ->GAP) : ->LOAD.
//  GAP: count GAP_CYCLES then ->IDLE; GAP_CYCLES==0 -> IDLE next cycle.
//  Latency: valid in IDLE -> ready pulse 1 cycle later (LOAD) -> tx_valid_o high the cycle after.
//  enable_i low mid-packet: current packet completes; only blocks new grants.
//  tx_done_i outside SEND: ignored. req_valid_i of non-owners: ignored, no ready.
//  Owner dropping valid in LOAD: tolerated until STALL_TO; byte in flight is never cut.
//  Pointer wrap: grant+1 == N_REQ -> 0. Single requester re-granted after its own GAP.
//  Counters sized $clog2(STALL_TO+1), $clog2(GAP_CYCLES+1); saturate, no wrap.
// STRUCTURE
//  uart_pkg: sched_state_e enum {IDLE,LOAD,SEND,GAP}; shared UART register/bit constants.
//  Sub-module uart_rr_pick: combinational one-hot winner from valid vector and pointer.
//  Top: FSM, data/last/grant/pointer registers, stall and gap counters.
// TESTING
//  Req0 sends 3 bytes A1,A2,A3(last), tx_done_i 5 cycles after each valid -> tx_data_o A1,A2,A3 in order, grant_o=0001 throughout.
//  Req0,req2 valid together, pointer 0 -> req0 packet, GAP 16 cycles, then req2; next tie -> req2 not first.
//  Req3 owns packet, req1 floods valid mid-packet -> no req_ready_o[1] until req3 last byte done.
//  Req1 stops after first non-last byte, STALL_TO=8 -> stall_err_o pulse 8 cycles into LOAD, grant_o=0, pointer=2.
//  enable_i low during SEND of byte 2 of 3 -> byte 3 still sent, no new grant until enable_i high.
//  rstn_i low while tx_valid_o=1 -> tx_valid_o, grant_o, busy_o 0 immediately; after release, req0 granted fresh.

Source files
------------

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmit scheduler and its helpers.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } sched_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner selection: first valid index at or after ptr, wrapping to 0.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any_valid
);

    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] pick;
    logic             found;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_upper
            assign upper[gi] = valid[gi] && (PTR_W'(gi) >= ptr);
        end
    endgenerate

    // Requesters above the pointer win first; otherwise wrap to the lowest valid one.
    assign pick      = (|upper) ? upper : valid;
    assign any_valid = |valid;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && pick[i]) begin
                winner_oh[i] = 1'b1;
                winner_idx   = PTR_W'(i);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx byte engine between N_REQ byte-stream requesters, one packet per grant,
// with a forced idle gap between packets and abort of owners that stall mid-packet.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 16,
    parameter int STALL_TO   = 1024
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     enable_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    input  logic [N_REQ-1:0]         req_last_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [UART_DATA_W-1:0]   tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_done_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     stall_err_o
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int STALL_W = $clog2(STALL_TO + 1);
    localparam int GAP_W   = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TO - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = (GAP_CYCLES < 1) ? '0 : GAP_W'(GAP_CYCLES - 1);

    sched_state_e             state_reg;
    logic [N_REQ-1:0]         grant_reg;
    logic [PTR_W-1:0]         grant_idx_reg;
    logic [PTR_W-1:0]         ptr_reg;
    logic [UART_DATA_W-1:0]   data_reg;
    logic                     last_reg;
    logic [STALL_W-1:0]       stall_cnt_reg;
    logic [GAP_W-1:0]         gap_cnt_reg;
    logic                     stall_err_reg;

    logic [N_REQ-1:0]         win_oh;
    logic [PTR_W-1:0]         win_idx;
    logic                     win_any;
    logic                     owner_valid;
    logic [UART_DATA_W-1:0]   owner_byte;
    logic                     owner_last;
    logic [PTR_W-1:0]         ptr_next;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid      (req_valid_i),
        .ptr        (ptr_reg),
        .winner_oh  (win_oh),
        .winner_idx (win_idx),
        .any_valid  (win_any)
    );

    assign owner_valid = |(grant_reg & req_valid_i);
    assign owner_byte  = req_data_i[{grant_idx_reg, 3'b000} +: UART_DATA_W];
    assign owner_last  = req_last_i[grant_idx_reg];
    assign ptr_next    = (grant_idx_reg == PTR_W'(N_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;

    // tx_valid drops in the tx_done cycle so uart_tx never sees a stale byte re-offered.
    assign req_ready_o = (state_reg == LOAD) ? (grant_reg & req_valid_i) : '0;
    assign tx_valid_o  = (state_reg == SEND) && !tx_done_i;
    assign tx_data_o   = data_reg;
    assign grant_o     = grant_reg;
    assign busy_o      = (state_reg != IDLE);
    assign stall_err_o = stall_err_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            ptr_reg       <= '0;
            data_reg      <= '0;
            last_reg      <= 1'b0;
            stall_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            stall_err_reg <= 1'b0;
        end else begin
            stall_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    stall_cnt_reg <= '0;
                    if (enable_i && win_any) begin
                        grant_reg     <= win_oh;
                        grant_idx_reg <= win_idx;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (owner_valid) begin
                        data_reg      <= owner_byte;
                        last_reg      <= owner_last;
                        stall_cnt_reg <= '0;
                        state_reg     <= SEND;
                    end else if (stall_cnt_reg == STALL_LAST) begin
                        stall_err_reg <= 1'b1;
                        stall_cnt_reg <= '0;
                        ptr_reg       <= ptr_next;
                        grant_reg     <= '0;
                        gap_cnt_reg   <= '0;
                        state_reg     <= GAP;
                    end else begin
                        stall_cnt_reg <= stall_cnt_reg + 1'b1;
                    end
                end
                SEND: begin
                    if (tx_done_i) begin
                        if (last_reg) begin
                            ptr_reg     <= ptr_next;
                            grant_reg   <= '0;
                            gap_cnt_reg <= '0;
                            state_reg   <= GAP;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
